// File: rtl/key_debounce.sv
// +----------------------------------------------------------------------------+
// | Module   : key_debounce                                                    |
// | Purpose  : Pushbutton debouncer with registered level, press and release   |
// |            pulses. Define KEY_DEBOUNCE_SYNC_EN to add a two-flop input     |
// |            synchronizer ahead of the filter.                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_db_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit                DIRECT   = (DEBOUNCE_CYCLES == 1);

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_CHECK_HIGH  = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_CHECK_LOW   = 2'd3;

  logic             s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_db_q, key_db_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef KEY_DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = key_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_db_d  = key_db_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_STABLE_LOW: begin
        if (s) begin
          // A one-cycle filter accepts on the first differing sample.
          if (DIRECT) begin
            state_d  = ST_STABLE_HIGH;
            key_db_d = 1'b1;
            press_d  = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = ST_CHECK_HIGH;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHECK_HIGH: begin
        if (!s) begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_STABLE_HIGH;
          key_db_d = 1'b1;
          press_d  = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE_HIGH: begin
        if (!s) begin
          if (DIRECT) begin
            state_d   = ST_STABLE_LOW;
            key_db_d  = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = ST_CHECK_LOW;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHECK_LOW: begin
        if (s) begin
          state_d = ST_STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_STABLE_LOW;
          key_db_d  = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = ST_STABLE_LOW;
        cnt_d    = '0;
        key_db_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_STABLE_LOW;
      cnt_q     <= '0;
      key_db_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_db_q  <= key_db_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_db_o        = key_db_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// Randomized bench for key_debounce: two instances (4-cycle and 1-cycle filter)
// checked every cycle against a sample-history model plus literal latency points.
`default_nettype none

module tb_key_debounce;

`ifdef KEY_DEBOUNCE_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int D0   = 4;
  localparam int D1   = 1;
  localparam int LAT0 = D0 + SYNC_DLY;
  localparam int LAT1 = D1 + SYNC_DLY;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b0;
  logic db0, pr0, rl0, db1, pr1, rl1;

  int n_checks = 0;
  int n_err = 0;

  key_debounce #(.DEBOUNCE_CYCLES(D0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key),
    .key_db_o(db0), .press_pulse_o(pr0), .release_pulse_o(rl0));

  key_debounce #(.DEBOUNCE_CYCLES(D1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key),
    .key_db_o(db1), .press_pulse_o(pr1), .release_pulse_o(rl1));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the filtered level flips once the newest D samples of s all
  // differ from it; samples taken before the last reset do not count.
  bit m_db[2], m_pr[2], m_rl[2];
  int m_n[2];
  bit m_h[2][16];
  bit m_kq[2];
  bit m_s, m_all;
  int m_d[2] = '{D0, D1};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kq = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
        m_db[i] = 1'b0; m_pr[i] = 1'b0; m_rl[i] = 1'b0; m_n[i] = 0;
        for (int j = 0; j < 16; j++) m_h[i][j] = 1'b0;
      end
    end else begin
      m_s = (SYNC_DLY == 2) ? m_kq[1] : key;
      m_kq[1] = m_kq[0];
      m_kq[0] = key;
      for (int i = 0; i < 2; i++) begin
        for (int j = 15; j > 0; j--) m_h[i][j] = m_h[i][j-1];
        m_h[i][0] = m_s;
        m_n[i]++;
        m_all = (m_n[i] >= m_d[i]);
        for (int j = 0; j < m_d[i]; j++) if (m_h[i][j] == m_db[i]) m_all = 1'b0;
        m_pr[i] = m_all && !m_db[i];
        m_rl[i] = m_all && m_db[i];
        if (m_all) m_db[i] = !m_db[i];
      end
    end
  end

  always @(negedge clk) begin
    chk("db0", db0, m_db[0]);
    chk("press0", pr0, m_pr[0]);
    chk("release0", rl0, m_rl[0]);
    chk("db1", db1, m_db[1]);
    chk("press1", pr1, m_pr[1]);
    chk("release1", rl1, m_rl[1]);
  end

  int c_rise;
  int n_press;
  int runlen;
  logic [7:0] bounce;

  initial begin
    // Reset held with a toggling key: everything stays low.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key = ~key;
      #1;
      chk("rst_db0", db0, 1'b0);
      chk("rst_press0", pr0, 1'b0);
    end

    // Key held high across reset release counts as a fresh press.
    @(negedge clk);
    key = 1'b1;
    #2 rst_n = 1'b1;
    for (int c = 1; c <= LAT0 + 1; c++) begin
      @(posedge clk); #1;
      chk("lat_db0", db0, (c >= LAT0));
      chk("lat_press0", pr0, (c == LAT0));
      chk("lat_db1", db1, (c >= LAT1));
      chk("lat_press1", pr1, (c == LAT1));
    end
    repeat (10) @(negedge clk);

    // Release and settle low.
    key = 1'b0;
    repeat (12) @(negedge clk);
    chk("settled_low", db0, 1'b0);

    // Bounce: short run rejected, final run accepted LAT0 edges after it starts.
    bounce = 8'b1111_0111;
    c_rise = 0;
    n_press = 0;
    for (int c = 1; c <= 20; c++) begin
      key = (c <= 8) ? bounce[c-1] : 1'b1;
      @(posedge clk); #1;
      if (pr0) n_press++;
      if (db0 && c_rise == 0) c_rise = c;
      @(negedge clk);
    end
    n_checks++;
    if (c_rise != 4 + LAT0) begin
      n_err++;
      $display("FAIL bounce_rise_edge: got %0d required %0d", c_rise, 4 + LAT0);
    end
    n_checks++;
    if (n_press != 1) begin
      n_err++;
      $display("FAIL bounce_press_count: got %0d required 1", n_press);
    end

    // Reset during a partial count: no press, count restarts afterwards.
    key = 1'b0;
    repeat (12) @(negedge clk);
    key = 1'b1;
    repeat (LAT0 - 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_db0", db0, 1'b0);
    chk("midrst_press0", pr0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 1; c <= LAT0; c++) begin
      @(posedge clk); #1;
      chk("restart_db0", db0, (c >= LAT0));
      chk("restart_press0", pr0, (c == LAT0));
    end
    @(negedge clk);

    // Randomized runs with occasional asynchronous resets.
    for (int r = 0; r < 600; r++) begin
      key = ~key;
      runlen = $urandom_range(1, 7);
      repeat (runlen) begin
        @(negedge clk);
        if ($urandom_range(0, 199) == 0) begin
          #2 rst_n = 1'b0;
          @(negedge clk);
          #2 rst_n = 1'b1;
        end
      end
    end
    key = 1'b1;
    repeat (20) @(negedge clk);
    chk("final_db0", db0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
